// File: rtl/fxp_mul_pipe.sv
// Pipelined signed fixed-point multiplier / MAC with round-half-away-from-zero,
// output saturation and a globally stalled valid/ready pipeline.
module fxp_mul_pipe #(
  parameter int A_W   = 16,
  parameter int B_W   = 16,
  parameter int OUT_W = 24,
  parameter int SHIFT = 14,
  parameter int PIPE  = 2,
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  input  logic             mode,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf
);

  localparam int PW = A_W + B_W;
  localparam int VW = ACC_W + 1;

  localparam logic signed [VW-1:0] HALF     = (VW'(1) << SHIFT) >> 1;
  localparam logic signed [VW-1:0] NEG_BIAS = (SHIFT == 0) ? '0 : HALF - VW'(1);
  localparam logic signed [VW-1:0] OMAX     = {{(VW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [VW-1:0] OMIN     = {{(VW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic                  advance;
  logic signed [PW-1:0]  prod_in;

  // Stage state packed flat so the shift works for any PIPE >= 1.
  logic [PIPE-1:0]       stg_valid_q, stg_valid_d;
  logic [PIPE-1:0]       stg_mode_q,  stg_mode_d;
  logic [PIPE-1:0]       stg_clr_q,   stg_clr_d;
  logic [PIPE*PW-1:0]    prod_q,      prod_d;

  logic [ACC_W-1:0]      acc_q,       acc_d;
  logic                  out_valid_q, out_valid_d;
  logic [OUT_W-1:0]      out_data_q,  out_data_d;
  logic                  out_ovf_q,   out_ovf_d;

  logic                  fin_valid, fin_mode, fin_clr;
  logic signed [PW-1:0]  prod_fin;
  logic signed [VW-1:0]  prod_vw, acc_base, acc_sum, v, biased, r;
  logic [ACC_W-1:0]      acc_new;
  logic                  acc_sat;

  assign prod_in = $signed({{B_W{a[A_W-1]}}, a}) * $signed({{A_W{b[B_W-1]}}, b});

  always_comb begin
    advance     = !out_valid_q || out_ready;
    in_ready    = advance;
    stg_valid_d = stg_valid_q;
    stg_mode_d  = stg_mode_q;
    stg_clr_d   = stg_clr_q;
    prod_d      = prod_q;
    if (advance) begin
      stg_valid_d = (stg_valid_q << 1) | PIPE'(in_valid);
      stg_mode_d  = (stg_mode_q  << 1) | PIPE'(mode);
      stg_clr_d   = (stg_clr_q   << 1) | PIPE'(acc_clr);
      prod_d      = (prod_q << PW) | (PIPE*PW)'(unsigned'(prod_in));
    end
  end

  always_comb begin
    fin_valid = stg_valid_q[PIPE-1];
    fin_mode  = stg_mode_q[PIPE-1];
    fin_clr   = stg_clr_q[PIPE-1];
    prod_fin  = $signed(prod_q[PIPE*PW-1 -: PW]);
    prod_vw   = {{(VW-PW){prod_fin[PW-1]}}, prod_fin};

    acc_base  = fin_clr ? '0 : {acc_q[ACC_W-1], acc_q};
    acc_sum   = acc_base + prod_vw;
    acc_sat   = acc_sum[VW-1] != acc_sum[VW-2];
    if (acc_sat)
      acc_new = acc_sum[VW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      acc_new = acc_sum[ACC_W-1:0];

    v      = fin_mode ? {acc_new[ACC_W-1], acc_new} : prod_vw;
    biased = v + (v[VW-1] ? NEG_BIAS : HALF);
    r      = biased >>> SHIFT;

    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    if (advance) begin
      out_valid_d = fin_valid;
      if (fin_valid) begin
        if (fin_mode)
          acc_d = acc_new;
        if (r > OMAX) begin
          out_data_d = {1'b0, {(OUT_W-1){1'b1}}};
          out_ovf_d  = 1'b1;
        end else if (r < OMIN) begin
          out_data_d = {1'b1, {(OUT_W-1){1'b0}}};
          out_ovf_d  = 1'b1;
        end else begin
          out_data_d = r[OUT_W-1:0];
          out_ovf_d  = fin_mode && acc_sat;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stg_valid_q <= '0;
      stg_mode_q  <= '0;
      stg_clr_q   <= '0;
      prod_q      <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      stg_valid_q <= stg_valid_d;
      stg_mode_q  <= stg_mode_d;
      stg_clr_q   <= stg_clr_d;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_fxp_mul_pipe.sv
// Bench for fxp_mul_pipe: arithmetic reference model fed at acceptance time,
// per-cycle output/handshake checking, and directed vectors with literal results.
module tb_fxp_mul_pipe;

  localparam int A_W = 16, B_W = 16, OUT_W = 24, SHIFT = 14, PIPE = 2, ACC_W = 48;

  logic             clk = 1'b0;
  logic             n_rst, in_valid, in_ready, mode, acc_clr;
  logic             out_valid, out_ready, out_ovf;
  logic [A_W-1:0]   a;
  logic [B_W-1:0]   b;
  logic [OUT_W-1:0] out_data;

  always #5 clk = ~clk;

  fxp_mul_pipe #(.A_W(A_W), .B_W(B_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .PIPE(PIPE), .ACC_W(ACC_W))
  dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
  );

  typedef struct {
    logic [OUT_W-1:0] d;
    logic             ovf;
  } res_t;

  res_t   exp_q[$];
  res_t   got_q[$];
  int     errors = 0;
  int     checks = 0;
  longint macc   = 0;
  logic   stalled = 1'b0;
  logic [OUT_W-1:0] hold_d;
  logic   hold_o;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
    end
  endtask

  // Reference: exact integer arithmetic, rounding as magnitude rounding.
  function automatic res_t model(input logic [A_W-1:0] ma, input logic [B_W-1:0] mb,
                                 input logic mm, input logic mc);
    res_t   res;
    longint p, v, r, s, h, amax, omax;
    bit     sat = 0;
    p    = longint'($signed(ma)) * longint'($signed(mb));
    amax = (longint'(1) <<< (ACC_W-1)) - 1;
    if (mm) begin
      v = mc ? p : macc + p;
      if (v > amax) begin v = amax; sat = 1; end
      else if (v < -amax - 1) begin v = -amax - 1; sat = 1; end
      macc = v;
    end else begin
      v = p;
    end
    s = longint'(1) <<< SHIFT;
    h = s / 2;
    r = (v >= 0) ? (v + h) / s : -((-v + h) / s);
    omax = (longint'(1) <<< (OUT_W-1)) - 1;
    if (r > omax) begin r = omax; sat = 1; end
    else if (r < -omax - 1) begin r = -omax - 1; sat = 1; end
    res.d   = OUT_W'(r);
    res.ovf = sat;
    return res;
  endfunction

  // Every cycle: handshake rule, stall stability, ordered result compare.
  always @(negedge clk) begin
    res_t e;
    if (!n_rst) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_ovf", out_ovf, 0);
      check("rst_in_ready", in_ready, 1);
      exp_q.delete();
      macc    = 0;
      stalled = 1'b0;
    end else begin
      check("in_ready_rule", in_ready, !out_valid || out_ready);
      if (stalled) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, hold_d);
        check("stall_ovf", out_ovf, hold_o);
      end
      if (out_valid && out_ready) begin
        check("out_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.d);
          check("out_ovf", out_ovf, e.ovf);
        end
        got_q.push_back('{d: out_data, ovf: out_ovf});
      end
      stalled = out_valid && !out_ready;
      hold_d  = out_data;
      hold_o  = out_ovf;
      if (in_valid && in_ready)
        exp_q.push_back(model(a, b, mode, acc_clr));
    end
  end

  task automatic send(input logic [A_W-1:0] ta, input logic [B_W-1:0] tb_,
                      input logic tm, input logic tc);
    bit ok = 0;
    int n  = 0;
    a = ta; b = tb_; mode = tm; acc_clr = tc; in_valid = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", exp_q.size() == 0 && !out_valid, 1);
  endtask

  task automatic expect_got(input string nm, input int idx, input logic [OUT_W-1:0] d, input logic o);
    if (idx >= got_q.size()) begin
      check({nm, "_missing"}, got_q.size(), idx + 1);
    end else begin
      check({nm, "_data"}, got_q[idx].d, d);
      check({nm, "_ovf"}, got_q[idx].ovf, o);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int tri_n[6] = '{1, 3, 6, 10, 15, 21};
    n_rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; mode = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    @(posedge clk); #1;

    // Basic MUL and latency
    got_q.delete();
    send(16'h4000, 16'hC000, 1'b0, 1'b0);
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    check("latency", lat, PIPE + 1);
    drain();
    expect_got("mul_basic", 0, 24'hFFC000, 1'b0);

    // Corners and rounding
    got_q.delete();
    send(16'h8000, 16'h8000, 1'b0, 1'b0);
    send(16'h0003, 16'h2000, 1'b0, 1'b0);
    send(16'hFFFD, 16'h2000, 1'b0, 1'b0);
    send(16'h0001, 16'h1000, 1'b0, 1'b0);
    send(16'h0001, 16'h2000, 1'b0, 1'b0);
    send(16'hFFFF, 16'h2000, 1'b0, 1'b0);
    send(16'h7FFF, 16'h8000, 1'b0, 1'b0);
    send(16'h0000, 16'h8000, 1'b0, 1'b0);
    drain();
    expect_got("min_sq", 0, 24'h010000, 1'b0);
    expect_got("rnd_p3", 1, 24'h000002, 1'b0);
    expect_got("rnd_m3", 2, 24'hFFFFFE, 1'b0);
    expect_got("rnd_q", 3, 24'h000000, 1'b0);
    expect_got("rnd_ph", 4, 24'h000001, 1'b0);
    expect_got("rnd_mh", 5, 24'hFFFFFF, 1'b0);
    expect_got("zero", 7, 24'h000000, 1'b0);

    // MAC run into output saturation, then clear
    got_q.delete();
    for (int k = 0; k < 129; k++)
      send(16'h7FFF, 16'h7FFF, 1'b1, k == 0);
    send(16'h4000, 16'h4000, 1'b1, 1'b1);
    drain();
    check("mac_count", got_q.size(), 130);
    expect_got("mac_128", 127, 24'h7FFE00, 1'b0);
    expect_got("mac_129", 128, 24'h7FFFFF, 1'b1);
    expect_got("mac_clr", 129, 24'h004000, 1'b0);

    // Backpressure with MAC beats
    got_q.delete();
    fork
      begin
        for (int k = 0; k < 6; k++)
          send(16'(16'h1000 * (k + 1)), 16'h4000, 1'b1, k == 0);
      end
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("bp_in_ready_low", in_ready, 0);
        check("bp_out_valid_high", out_valid, 1);
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", got_q.size(), 6);
    for (int k = 0; k < 6; k++)
      expect_got("bp_sum", k, 24'(tri_n[k] * 4096), 1'b0);

    // MUL between MAC beats leaves acc alone
    got_q.delete();
    send(16'h4000, 16'h4000, 1'b1, 1'b1);
    send(16'h2000, 16'h4000, 1'b0, 1'b0);
    send(16'h4000, 16'h4000, 1'b1, 1'b0);
    drain();
    expect_got("il_mac0", 0, 24'h004000, 1'b0);
    expect_got("il_mul", 1, 24'h002000, 1'b0);
    expect_got("il_mac1", 2, 24'h008000, 1'b0);

    // Reset with beats in flight
    got_q.delete();
    send(16'h4000, 16'h4000, 1'b1, 1'b0);
    send(16'h1234, 16'h0100, 1'b0, 1'b0);
    send(16'h4000, 16'h4000, 1'b1, 1'b0);
    n_rst = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_data", out_data, 0);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    @(posedge clk); #1;
    send(16'h4000, 16'h4000, 1'b1, 1'b0);
    drain();
    check("post_rst_count", got_q.size(), 1);
    expect_got("post_rst_acc", 0, 24'h004000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
